// File: rtl/mem_port_arbiter_pkg.sv
// Shared defines and types for the IF/DM memory-port arbiter.
// Width and FSM defaults live here as macros so the rest of the slice sees them via the package.
`ifndef MEM_PORT_ARBITER_DEFINES
`define MEM_PORT_ARBITER_DEFINES
`define DWIDTH          32
`define PC_WIDTH        32
`define ARB_IDLE        2'd0
`define ARB_BUSY_IF     2'd1
`define ARB_BUSY_DM     2'd2
`define ARB_STARVE_MAX  4
`define ARB_TIMEOUT     64
`endif

package mem_port_arbiter_pkg;

   localparam int unsigned ARB_DWIDTH     = `DWIDTH;
   localparam int unsigned ARB_AWIDTH     = `PC_WIDTH;
   localparam int unsigned ARB_STARVE_MAX = `ARB_STARVE_MAX;
   localparam int unsigned ARB_TIMEOUT    = `ARB_TIMEOUT;
   localparam int unsigned STARVE_W       = 4;
   localparam int unsigned WDOG_W         = 8;
   localparam int unsigned MASK_W         = 4;

   typedef enum logic [1:0] {
      S_IDLE    = `ARB_IDLE,
      S_BUSY_IF = `ARB_BUSY_IF,
      S_BUSY_DM = `ARB_BUSY_DM
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles from a clear and flags the TIMEOUT-th one.
module arb_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic d_clk,
   input  logic d_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire_c
);

   logic [WDOG_W-1:0] r_cnt;

   // Count is 0 in the first busy cycle, so expiry lands on busy cycle TIMEOUT.
   assign o_expire_c = i_en & (r_cnt == WDOG_W'(TIMEOUT - 1));

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire_c) begin
         r_cnt <= r_cnt + WDOG_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory.
// DM has priority, bounded by a starvation counter; a watchdog aborts hung transactions.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DWIDTH     = ARB_DWIDTH,
   parameter int unsigned AWIDTH     = ARB_AWIDTH,
   parameter int unsigned STARVE_MAX = ARB_STARVE_MAX,
   parameter int unsigned TIMEOUT    = ARB_TIMEOUT
) (
   input  logic              d_clk,
   input  logic              d_rst,
   input  logic              if_i_req,
   input  logic [AWIDTH-1:0] if_i_addr,
   output logic              if_o_ack,
   output logic [DWIDTH-1:0] if_o_rdata,
   input  logic              dm_i_req,
   input  logic              dm_i_we,
   input  logic [3:0]        dm_i_mask,
   input  logic [AWIDTH-1:0] dm_i_addr,
   input  logic [DWIDTH-1:0] dm_i_wdata,
   output logic              dm_o_ack,
   output logic [DWIDTH-1:0] dm_o_rdata,
   output logic              mem_o_req,
   output logic              mem_o_we,
   output logic [3:0]        mem_o_mask,
   output logic [AWIDTH-1:0] mem_o_addr,
   output logic [DWIDTH-1:0] mem_o_wdata,
   input  logic              mem_i_ack,
   input  logic [DWIDTH-1:0] mem_i_rdata,
   output logic              o_stall_if,
   output logic              o_stall_dm,
   output logic              o_err
);

   arb_state_e          r_state;
   arb_state_e          w_next;
   logic [STARVE_W-1:0] r_starve;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [MASK_W-1:0]   r_mem_mask;
   logic [AWIDTH-1:0]   r_mem_addr;
   logic [DWIDTH-1:0]   r_mem_wdata;
   logic                r_err;
   logic                w_grant_if;
   logic                w_grant_dm;
   logic                w_done;
   logic                w_expire;
   logic                w_busy;

   assign w_busy = (r_state != S_IDLE);

   arb_watchdog #(
      .TIMEOUT    (TIMEOUT)
   ) u_watchdog (
      .d_clk      (d_clk),
      .d_rst      (d_rst),
      .i_clr      (w_grant_if | w_grant_dm),
      .i_en       (w_busy),
      .o_expire_c (w_expire)
   );

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Arbitration in IDLE; a transaction ends on memory ack or watchdog expiry.
   always_comb begin
      w_next     = r_state;
      w_grant_if = 1'b0;
      w_grant_dm = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dm_i_req && ((r_starve < STARVE_W'(STARVE_MAX)) || !if_i_req)) begin
               w_grant_dm = 1'b1;
               w_next     = S_BUSY_DM;
            end else if (if_i_req) begin
               w_grant_if = 1'b1;
               w_next     = S_BUSY_IF;
            end
         end
         S_BUSY_IF, S_BUSY_DM: begin
            if (mem_i_ack || w_expire) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_mask  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_starve    <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_i_we;
            r_mem_mask  <= dm_i_mask;
            r_mem_addr  <= dm_i_addr;
            r_mem_wdata <= dm_i_wdata;
            if (if_i_req && (r_starve != STARVE_W'(STARVE_MAX))) begin
               r_starve <= r_starve + STARVE_W'(1);
            end
         end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_mask  <= '1;
            r_mem_addr  <= if_i_addr;
            r_mem_wdata <= '0;
            r_starve    <= '0;
         end else if (w_done) begin
            r_mem_req <= 1'b0;
            if (!mem_i_ack) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign mem_o_req   = r_mem_req;
   assign mem_o_we    = r_mem_we;
   assign mem_o_mask  = r_mem_mask;
   assign mem_o_addr  = r_mem_addr;
   assign mem_o_wdata = r_mem_wdata;
   assign o_err       = r_err;

   // Completion is returned in the ack cycle; a watchdog abort returns zero data.
   assign if_o_ack   = (r_state == S_BUSY_IF) && w_done;
   assign dm_o_ack   = (r_state == S_BUSY_DM) && w_done;
   assign if_o_rdata = ((r_state == S_BUSY_IF) && mem_i_ack) ? mem_i_rdata : '0;
   assign dm_o_rdata = ((r_state == S_BUSY_DM) && mem_i_ack) ? mem_i_rdata : '0;
   assign o_stall_if = if_i_req & ~if_o_ack;
   assign o_stall_dm = dm_i_req & ~dm_o_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int SM = 4;
   localparam int TO = 64;

   logic          d_clk;
   logic          d_rst;
   logic          if_i_req;
   logic [AW-1:0] if_i_addr;
   logic          if_o_ack;
   logic [DW-1:0] if_o_rdata;
   logic          dm_i_req;
   logic          dm_i_we;
   logic [3:0]    dm_i_mask;
   logic [AW-1:0] dm_i_addr;
   logic [DW-1:0] dm_i_wdata;
   logic          dm_o_ack;
   logic [DW-1:0] dm_o_rdata;
   logic          mem_o_req;
   logic          mem_o_we;
   logic [3:0]    mem_o_mask;
   logic [AW-1:0] mem_o_addr;
   logic [DW-1:0] mem_o_wdata;
   logic          mem_i_ack;
   logic [DW-1:0] mem_i_rdata;
   logic          o_stall_if;
   logic          o_stall_dm;
   logic          o_err;

   mem_port_arbiter #(
      .DWIDTH     (DW),
      .AWIDTH     (AW),
      .STARVE_MAX (SM),
      .TIMEOUT    (TO)
   ) dut (
      .d_clk       (d_clk),
      .d_rst       (d_rst),
      .if_i_req    (if_i_req),
      .if_i_addr   (if_i_addr),
      .if_o_ack    (if_o_ack),
      .if_o_rdata  (if_o_rdata),
      .dm_i_req    (dm_i_req),
      .dm_i_we     (dm_i_we),
      .dm_i_mask   (dm_i_mask),
      .dm_i_addr   (dm_i_addr),
      .dm_i_wdata  (dm_i_wdata),
      .dm_o_ack    (dm_o_ack),
      .dm_o_rdata  (dm_o_rdata),
      .mem_o_req   (mem_o_req),
      .mem_o_we    (mem_o_we),
      .mem_o_mask  (mem_o_mask),
      .mem_o_addr  (mem_o_addr),
      .mem_o_wdata (mem_o_wdata),
      .mem_i_ack   (mem_i_ack),
      .mem_i_rdata (mem_i_rdata),
      .o_stall_if  (o_stall_if),
      .o_stall_dm  (o_stall_dm),
      .o_err       (o_err)
   );

   initial d_clk = 1'b0;
   always #5 d_clk = ~d_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge d_clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      if_i_req    = 1'b0;
      if_i_addr   = '0;
      dm_i_req    = 1'b0;
      dm_i_we     = 1'b0;
      dm_i_mask   = '0;
      dm_i_addr   = '0;
      dm_i_wdata  = '0;
      mem_i_ack   = 1'b0;
      mem_i_rdata = '0;
   endtask

   task automatic do_reset();
      d_rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge d_clk);
      #1;
      d_rst = 1'b1;
   endtask

   typedef struct {
      logic        if_req;
      logic        dm_req;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic        e_req;
      logic        e_we;
      logic [3:0]  e_mask;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_if_ack;
      logic        e_dm_ack;
      logic [31:0] e_if_rd;
      logic [31:0] e_dm_rd;
      logic        e_st_if;
      logic        e_st_dm;
   } vec_t;

   vec_t tbl[8];

   // Reference model state (transaction level)
   int          m_owner;   // 0 none, 1 IF, 2 DM
   int          m_age;     // busy cycle number, first busy cycle is 1
   int          m_starve;
   bit          m_err;
   logic [31:0] m_addr;
   logic        m_we;
   logic [3:0]  m_mask;
   logic [31:0] m_wdata;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          dm_cnt;
      int          segs;
      int          busy;
      bit          got_ack;
      bit          p_if_ack;
      bit          p_dm_ack;
      bit          ack_en;
      bit          done;
      logic        old_req;
      logic [31:0] exp_rd;

      // Reset values
      do_reset();
      d_rst = 1'b0;
      settle();
      chk("reset.mem_req",   64'(mem_o_req),   0);
      chk("reset.mem_we",    64'(mem_o_we),    0);
      chk("reset.mem_mask",  64'(mem_o_mask),  0);
      chk("reset.mem_addr",  64'(mem_o_addr),  0);
      chk("reset.mem_wdata", 64'(mem_o_wdata), 0);
      chk("reset.acks",      64'({if_o_ack, dm_o_ack}), 0);
      chk("reset.rdata",     64'({if_o_rdata, dm_o_rdata}), 0);
      chk("reset.err",       64'(o_err), 0);
      d_rst = 1'b1;

      // Vector table: simultaneous IF + DM store, then spurious ack in IDLE
      tbl[0] = '{1, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0,        1, 1};
      tbl[1] = '{1, 1, 0, 32'h0,        1, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 32'h0,        32'h0,        1, 1};
      tbl[2] = '{1, 1, 1, 32'hAAAA5555, 1, 1, 4'h3, 32'h100, 32'h12345678, 0, 1, 32'h0,        32'hAAAA5555, 1, 0};
      tbl[3] = '{1, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0,        1, 0};
      tbl[4] = '{1, 0, 0, 32'h0,        1, 0, 4'hF, 32'h200, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0};
      tbl[5] = '{1, 0, 1, 32'hCAFEF00D, 1, 0, 4'hF, 32'h200, 32'h0,        1, 0, 32'hCAFEF00D, 32'h0,        0, 0};
      tbl[6] = '{0, 0, 1, 32'h11111111, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0,        0, 0};
      tbl[7] = '{0, 0, 1, 32'h22222222, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0,        0, 0};
      dm_i_we    = 1'b1;
      dm_i_mask  = 4'b0011;
      dm_i_addr  = 32'h100;
      dm_i_wdata = 32'h12345678;
      if_i_addr  = 32'h200;
      for (int i = 0; i < 8; i++) begin
         tick();
         if_i_req    = tbl[i].if_req;
         dm_i_req    = tbl[i].dm_req;
         mem_i_ack   = tbl[i].mem_ack;
         mem_i_rdata = tbl[i].mem_rdata;
         settle();
         chk($sformatf("vec%0d.mem_req", i),  64'(mem_o_req),  64'(tbl[i].e_req));
         if (tbl[i].e_req) begin
            chk($sformatf("vec%0d.mem_we", i),    64'(mem_o_we),    64'(tbl[i].e_we));
            chk($sformatf("vec%0d.mem_mask", i),  64'(mem_o_mask),  64'(tbl[i].e_mask));
            chk($sformatf("vec%0d.mem_addr", i),  64'(mem_o_addr),  64'(tbl[i].e_addr));
            chk($sformatf("vec%0d.mem_wdata", i), 64'(mem_o_wdata), 64'(tbl[i].e_wdata));
         end
         chk($sformatf("vec%0d.if_ack", i),   64'(if_o_ack),   64'(tbl[i].e_if_ack));
         chk($sformatf("vec%0d.dm_ack", i),   64'(dm_o_ack),   64'(tbl[i].e_dm_ack));
         chk($sformatf("vec%0d.if_rdata", i), 64'(if_o_rdata), 64'(tbl[i].e_if_rd));
         chk($sformatf("vec%0d.dm_rdata", i), 64'(dm_o_rdata), 64'(tbl[i].e_dm_rd));
         chk($sformatf("vec%0d.stall_if", i), 64'(o_stall_if), 64'(tbl[i].e_st_if));
         chk($sformatf("vec%0d.stall_dm", i), 64'(o_stall_dm), 64'(tbl[i].e_st_dm));
      end
      tick();
      idle_inputs();

      // IF-only read at 0x40, memory acks on the 4th busy cycle
      tick();
      if_i_req  = 1'b1;
      if_i_addr = 32'h40;
      settle();
      chk("ifread.c0.stall_if", 64'(o_stall_if), 1);
      chk("ifread.c0.mem_req",  64'(mem_o_req),  0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         mem_i_ack   = (c == 4);
         mem_i_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
         settle();
         chk($sformatf("ifread.c%0d.mem_req", c),  64'(mem_o_req),  1);
         chk($sformatf("ifread.c%0d.mem_we", c),   64'(mem_o_we),   0);
         chk($sformatf("ifread.c%0d.mem_mask", c), 64'(mem_o_mask), 64'hF);
         chk($sformatf("ifread.c%0d.mem_addr", c), 64'(mem_o_addr), 64'h40);
         chk($sformatf("ifread.c%0d.if_ack", c),   64'(if_o_ack),   64'(c == 4));
         chk($sformatf("ifread.c%0d.stall_if", c), 64'(o_stall_if), 64'(c != 4));
         if (c == 4) chk("ifread.rdata", 64'(if_o_rdata), 64'hDEADBEEF);
      end
      tick();
      idle_inputs();
      settle();
      chk("ifread.after.mem_req", 64'(mem_o_req), 0);
      chk("ifread.after.if_ack",  64'(if_o_ack),  0);

      // Starvation: DM and IF both hold requests; memory acks immediately
      tick();
      if_i_req  = 1'b1;
      if_i_addr = 32'h80;
      dm_i_req  = 1'b1;
      dm_i_we   = 1'b0;
      dm_i_mask = 4'hF;
      dm_i_addr = 32'h400;
      dm_cnt = 0;
      segs   = 0;
      for (int c = 0; c < 80 && segs < 2; c++) begin
         tick();
         mem_i_ack   = mem_o_req;
         mem_i_rdata = 32'h0BADF00D;
         settle();
         if (dm_o_ack) dm_cnt++;
         if (if_o_ack) begin
            chk($sformatf("starve.dm_grants_before_if%0d", segs), 64'(dm_cnt), SM);
            dm_cnt = 0;
            segs++;
         end
      end
      chk("starve.if_grants_seen", 64'(segs), 2);
      tick();
      idle_inputs();

      // Watchdog: memory never acks a DM load
      tick();
      dm_i_req  = 1'b1;
      dm_i_we   = 1'b0;
      dm_i_mask = 4'hF;
      dm_i_addr = 32'h300;
      settle();
      busy    = 0;
      got_ack = 1'b0;
      for (int c = 0; c < 200 && !got_ack; c++) begin
         tick();
         settle();
         if (mem_o_req) busy++;
         if (dm_o_ack) begin
            got_ack = 1'b1;
            chk("timeout.rdata", 64'(dm_o_rdata), 0);
         end
      end
      chk("timeout.ack_seen",   64'(got_ack), 1);
      chk("timeout.busy_cycle", 64'(busy), TO);
      tick();
      dm_i_req = 1'b0;
      settle();
      chk("timeout.err_set", 64'(o_err), 1);
      chk("timeout.mem_req", 64'(mem_o_req), 0);
      tick();
      if_i_req  = 1'b1;
      if_i_addr = 32'h44;
      settle();
      tick();
      mem_i_ack   = 1'b1;
      mem_i_rdata = 32'h5A5A5A5A;
      settle();
      chk("timeout.next_if_ack",   64'(if_o_ack),   1);
      chk("timeout.next_if_rdata", 64'(if_o_rdata), 64'h5A5A5A5A);
      tick();
      idle_inputs();
      settle();
      tick();
      settle();
      chk("timeout.err_sticky", 64'(o_err), 1);

      // Reset during BUSY_DM, stray ack afterwards
      tick();
      dm_i_req  = 1'b1;
      dm_i_we   = 1'b1;
      dm_i_addr = 32'h500;
      settle();
      tick();
      settle();
      chk("rstmid.busy_req", 64'(mem_o_req), 1);
      #1;
      d_rst = 1'b0;
      #1;
      chk("rstmid.req_dropped", 64'(mem_o_req), 0);
      chk("rstmid.err_cleared", 64'(o_err), 0);
      chk("rstmid.dm_ack",      64'(dm_o_ack), 0);
      tick();
      dm_i_req    = 1'b0;
      mem_i_ack   = 1'b1;
      mem_i_rdata = 32'h77777777;
      settle();
      chk("rstmid.stray_dm_ack", 64'(dm_o_ack), 0);
      chk("rstmid.stray_rdata",  64'(dm_o_rdata), 0);
      d_rst = 1'b1;
      tick();
      settle();
      chk("rstmid.post_dm_ack",  64'(dm_o_ack), 0);
      chk("rstmid.post_if_ack",  64'(if_o_ack), 0);
      chk("rstmid.post_mem_req", 64'(mem_o_req), 0);

      // Randomized traffic against the reference model
      do_reset();
      m_owner  = 0;
      m_age    = 0;
      m_starve = 0;
      m_err    = 1'b0;
      m_addr   = '0;
      m_we     = 1'b0;
      m_mask   = '0;
      m_wdata  = '0;
      p_if_ack = 1'b0;
      p_dm_ack = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         tick();
         old_req = if_i_req;
         if (if_i_req && p_if_ack) if_i_req = ($urandom_range(0, 1) == 0);
         else if (!if_i_req)       if_i_req = ($urandom_range(0, 2) == 0);
         if (if_i_req && (p_if_ack || !old_req)) if_i_addr = $urandom & 32'hFFFF_FFFC;
         old_req = dm_i_req;
         if (dm_i_req && p_dm_ack) dm_i_req = ($urandom_range(0, 1) == 0);
         else if (!dm_i_req)       dm_i_req = ($urandom_range(0, 1) == 0);
         if (dm_i_req && (p_dm_ack || !old_req)) begin
            dm_i_we    = ($urandom_range(0, 1) == 1);
            dm_i_mask  = 4'($urandom_range(0, 15));
            dm_i_addr  = $urandom;
            dm_i_wdata = $urandom;
         end
         ack_en      = ((i / 300) % 4) != 3;
         mem_i_ack   = ack_en && ($urandom_range(0, 2) == 0);
         mem_i_rdata = $urandom;
         settle();

         done   = (m_owner != 0) && (mem_i_ack || m_age == TO);
         exp_rd = mem_i_ack ? mem_i_rdata : 32'h0;
         chk($sformatf("rnd%0d.mem_req", i),  64'(mem_o_req), 64'(m_owner != 0));
         if (m_owner != 0) begin
            chk($sformatf("rnd%0d.mem_addr", i),  64'(mem_o_addr),  64'(m_addr));
            chk($sformatf("rnd%0d.mem_we", i),    64'(mem_o_we),    64'(m_we));
            chk($sformatf("rnd%0d.mem_mask", i),  64'(mem_o_mask),  64'(m_mask));
            chk($sformatf("rnd%0d.mem_wdata", i), 64'(mem_o_wdata), 64'(m_wdata));
         end
         chk($sformatf("rnd%0d.if_ack", i),   64'(if_o_ack),   64'(done && m_owner == 1));
         chk($sformatf("rnd%0d.dm_ack", i),   64'(dm_o_ack),   64'(done && m_owner == 2));
         chk($sformatf("rnd%0d.if_rdata", i), 64'(if_o_rdata), (done && m_owner == 1) ? 64'(exp_rd) : 64'h0);
         chk($sformatf("rnd%0d.dm_rdata", i), 64'(dm_o_rdata), (done && m_owner == 2) ? 64'(exp_rd) : 64'h0);
         chk($sformatf("rnd%0d.stall_if", i), 64'(o_stall_if), 64'(if_i_req && !(done && m_owner == 1)));
         chk($sformatf("rnd%0d.stall_dm", i), 64'(o_stall_dm), 64'(dm_i_req && !(done && m_owner == 2)));
         chk($sformatf("rnd%0d.err", i),      64'(o_err),      64'(m_err));

         p_if_ack = done && (m_owner == 1);
         p_dm_ack = done && (m_owner == 2);
         if (m_owner == 0) begin
            if (dm_i_req && (m_starve < SM || !if_i_req)) begin
               m_owner = 2;
               m_age   = 1;
               if (if_i_req && m_starve < SM) m_starve++;
               m_addr  = dm_i_addr;
               m_we    = dm_i_we;
               m_mask  = dm_i_mask;
               m_wdata = dm_i_wdata;
            end else if (if_i_req) begin
               m_owner  = 1;
               m_age    = 1;
               m_starve = 0;
               m_addr   = if_i_addr;
               m_we     = 1'b0;
               m_mask   = 4'hF;
               m_wdata  = 32'h0;
            end
         end else if (done) begin
            if (!mem_i_ack) m_err = 1'b1;
            m_owner = 0;
         end else begin
            m_age++;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
